// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for alu_mdu -- ALU function codes, the
// multiply/divide selector and the FSM state encoding.
package alu_pkg;

    // Function codes, decoded only when in_md selects the ALU
    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;
    localparam logic [5:0] ALU_AND = 6'b011000;
    localparam logic [5:0] ALU_OR  = 6'b011110;
    localparam logic [5:0] ALU_XOR = 6'b010110;
    localparam logic [5:0] ALU_NOR = 6'b010001;
    localparam logic [5:0] ALU_A   = 6'b011010;
    localparam logic [5:0] ALU_SLL = 6'b100000;
    localparam logic [5:0] ALU_SRL = 6'b100001;
    localparam logic [5:0] ALU_SRA = 6'b100011;
    localparam logic [5:0] ALU_EQ  = 6'b110011;
    localparam logic [5:0] ALU_NE  = 6'b110001;
    localparam logic [5:0] ALU_LT  = 6'b110101;
    localparam logic [5:0] ALU_LEZ = 6'b111101;
    localparam logic [5:0] ALU_LTZ = 6'b111011;
    localparam logic [5:0] ALU_GTZ = 6'b111111;

    // Operation class; 2'b11 is reserved and behaves as MD_ALU
    localparam logic [1:0] MD_ALU = 2'b00;
    localparam logic [1:0] MD_MUL = 2'b01;
    localparam logic [1:0] MD_DIV = 2'b10;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/response handshake bundle for alu_mdu.
// master = the pipeline issuing operations, slave = the alu_mdu unit.
interface alu_mdu_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [5:0]       in_alufun;
    logic [1:0]       in_md;
    logic             in_sign;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_lo;
    logic [WIDTH-1:0] out_hi;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, in_alufun, in_md, in_sign, out_ready,
        input  in_ready, out_valid, out_lo, out_hi, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_alufun, in_md, in_sign, out_ready,
        output in_ready, out_valid, out_lo, out_hi, out_err
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational single-cycle ALU. Shifts move B by A[SHW-1:0];
// compares return 0/1; undefined function codes return 0.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [5:0]       i_alufun,
    input  logic             i_sign,
    output logic [WIDTH-1:0] o_y
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic [SHW-1:0] w_shamt;
    logic           w_lt;

    assign w_shamt = i_a[SHW-1:0];
    assign w_lt    = i_sign ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);

    // Decode the function code into the result word
    always_comb begin
        o_y = '0;
        case (i_alufun)
            ALU_ADD: o_y = i_a + i_b;
            ALU_SUB: o_y = i_a - i_b;
            ALU_AND: o_y = i_a & i_b;
            ALU_OR:  o_y = i_a | i_b;
            ALU_XOR: o_y = i_a ^ i_b;
            ALU_NOR: o_y = ~(i_a | i_b);
            ALU_A:   o_y = i_a;
            ALU_SLL: o_y = i_b << w_shamt;
            ALU_SRL: o_y = i_b >> w_shamt;
            ALU_SRA: o_y = $unsigned($signed(i_b) >>> w_shamt);
            ALU_EQ:  o_y = WIDTH'(i_a == i_b);
            ALU_NE:  o_y = WIDTH'(i_a != i_b);
            ALU_LT:  o_y = WIDTH'(w_lt);
            ALU_LEZ: o_y = WIDTH'(i_a[WIDTH-1] || (i_a == '0));
            ALU_LTZ: o_y = WIDTH'(i_a[WIDTH-1]);
            ALU_GTZ: o_y = WIDTH'(!i_a[WIDTH-1] && (i_a != '0));
            default: o_y = '0;
        endcase
    end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: handshaked ALU with iterative HI/LO multiply/divide.
// Every result is registered and held until out_ready. Define
// ALU_MDU_DIV_EN to build the restoring divider; without it DIV ops
// finish in one cycle with zero results and out_err set.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic      clk,
    input logic      reset,
    alu_mdu_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic [1:0]       r_state;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_op;      // multiplicand or divisor magnitude
    logic             r_neg_lo;  // negate product / quotient at the end
    logic             r_err;
`ifdef ALU_MDU_DIV_EN
    logic             r_div;
    logic             r_neg_hi;  // remainder follows the dividend's sign
    logic [WIDTH:0]   w_div_shl;
    logic [WIDTH:0]   w_div_dif;
`endif

    logic             w_accept;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_alu_y;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_nx_hi;
    logic [WIDTH-1:0] w_nx_lo;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .i_a      (bus.in_a),
        .i_b      (bus.in_b),
        .i_alufun (bus.in_alufun),
        .i_sign   (bus.in_sign),
        .o_y      (w_alu_y)
    );

    assign bus.in_ready  = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_lo    = r_lo;
    assign bus.out_hi    = r_hi;
    assign bus.out_err   = r_err;

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_neg_a  = bus.in_sign && bus.in_a[WIDTH-1];
    assign w_neg_b  = bus.in_sign && bus.in_b[WIDTH-1];
    assign w_mag_a  = w_neg_a ? -bus.in_a : bus.in_a;
    assign w_mag_b  = w_neg_b ? -bus.in_b : bus.in_b;

    // One multiply or divide step, plus the sign fix-up applied on the last step
    always_comb begin
        w_addend  = r_lo[0] ? r_op : '0;
        w_mul_sum = {1'b0, r_hi} + {1'b0, w_addend};
        // Shift-add: carry out of the add lands in the top of {hi,lo}
        {w_nx_hi, w_nx_lo} = {w_mul_sum, r_lo[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
        w_div_shl = {r_hi, r_lo[WIDTH-1]};
        w_div_dif = w_div_shl - {1'b0, r_op};
        if (r_div) begin
            if (!w_div_dif[WIDTH]) begin
                w_nx_hi = w_div_dif[WIDTH-1:0];
                w_nx_lo = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_nx_hi = w_div_shl[WIDTH-1:0];
                w_nx_lo = {r_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
        {w_res_hi, w_res_lo} = r_neg_lo ? -{w_nx_hi, w_nx_lo} : {w_nx_hi, w_nx_lo};
`ifdef ALU_MDU_DIV_EN
        if (r_div) begin
            w_res_lo = r_neg_lo ? -w_nx_lo : w_nx_lo;
            w_res_hi = r_neg_hi ? -w_nx_hi : w_nx_hi;
        end
`endif
    end

    // FSM, operand capture and iteration registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_op     <= '0;
            r_neg_lo <= 1'b0;
            r_err    <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            r_div    <= 1'b0;
            r_neg_hi <= 1'b0;
`endif
        end else if (r_state == BUSY) begin
            if (r_cnt == '0) begin
                r_hi    <= w_res_hi;
                r_lo    <= w_res_lo;
                r_state <= DONE;
            end else begin
                r_hi  <= w_nx_hi;
                r_lo  <= w_nx_lo;
                r_cnt <= r_cnt - 1'b1;
            end
        end else if (w_accept) begin
            r_err <= 1'b0;
            r_hi  <= '0;
            case (bus.in_md)
                MD_MUL: begin
                    r_state  <= BUSY;
                    r_cnt    <= SHW'(WIDTH - 1);
                    r_lo     <= w_mag_a;
                    r_op     <= w_mag_b;
                    r_neg_lo <= w_neg_a ^ w_neg_b;
`ifdef ALU_MDU_DIV_EN
                    r_div    <= 1'b0;
`endif
                end
                MD_DIV: begin
`ifdef ALU_MDU_DIV_EN
                    if (bus.in_b == '0) begin
                        r_state <= DONE;
                        r_lo    <= '1;
                        r_hi    <= bus.in_a;
                        r_err   <= 1'b1;
                    end else begin
                        r_state  <= BUSY;
                        r_cnt    <= SHW'(WIDTH - 1);
                        r_lo     <= w_mag_a;
                        r_op     <= w_mag_b;
                        r_neg_lo <= w_neg_a ^ w_neg_b;
                        r_neg_hi <= w_neg_a;
                        r_div    <= 1'b1;
                    end
`else
                    r_state <= DONE;
                    r_lo    <= '0;
                    r_err   <= 1'b1;
`endif
                end
                default: begin
                    r_state <= DONE;
                    r_lo    <= w_alu_y;
                end
            endcase
        end else if ((r_state != DONE) || bus.out_ready) begin
            // Result consumed with nothing new offered; also recovers the unused encoding
            r_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vectors for alu_mdu. The driver pushes each hand-computed
// expected response into a queue at acceptance; an independent monitor pops
// and compares whenever a result is handed over, including its latency.
module tb_alu_mdu;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         err;
        int           lat;
        int           acc;
        string        name;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   seen   = 1'b0;
    exp_t q[$];

    alu_mdu_if #(.WIDTH(W)) bus ();

    alu_mdu #(
        .WIDTH(W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one op at the current negedge; record the expected result on acceptance
    task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [5:0] fun, input logic [1:0] md, input logic sgn,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi, input logic eerr,
                         input int lat, input bit nowait);
        exp_t e;
        int   t = 0;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_alufun = fun;
        bus.in_md     = md;
        bus.in_sign   = sgn;
        #1;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (nowait) chk({name, "_wait"}, 64'(t), 64'd0);
        if (!bus.in_ready) begin
            chk({name, "_accept"}, 64'd0, 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        e.lo   = elo;
        e.hi   = ehi;
        e.err  = eerr;
        e.lat  = lat;
        e.acc  = cyc;
        e.name = name;
        q.push_back(e);
        @(negedge clk);
        // Scramble the operands so a design that fails to capture them shows it
        bus.in_valid  = 1'b0;
        bus.in_a      = 32'hDEAD_BEEF;
        bus.in_b      = 32'h0BAD_F00D;
        bus.in_alufun = 6'b111111;
        bus.in_md     = 2'b00;
        bus.in_sign   = ~sgn;
    endtask

    task automatic wait_empty();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    // Monitor: samples just before the rising edge so it sees the final handshake values
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                seen = 1'b0;
            end else if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    if (!seen) begin
                        chk({q[0].name, "_lat"}, 64'(cyc - q[0].acc), 64'(q[0].lat));
                        seen = 1'b1;
                    end
                    if (bus.out_ready) begin
                        chk({q[0].name, "_lo"}, 64'(bus.out_lo), 64'(q[0].lo));
                        chk({q[0].name, "_hi"}, 64'(bus.out_hi), 64'(q[0].hi));
                        chk({q[0].name, "_err"}, 64'(bus.out_err), 64'(q[0].err));
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n_valid;
        int t;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_alufun = '0;
        bus.in_md     = '0;
        bus.in_sign   = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_err", 64'(bus.out_err), 64'd0);
        chk("reset_lo", 64'(bus.out_lo), 64'd0);
        chk("reset_hi", 64'(bus.out_hi), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);

        // Back-to-back ALU ops, one per cycle
        issue("add_ovf", 32'h7FFF_FFFF, 32'h1, ALU_ADD, MD_ALU, 1'b1, 32'h8000_0000, '0, 1'b0, 1, 1'b1);
        issue("sll", 32'h4, 32'h1, ALU_SLL, MD_ALU, 1'b0, 32'h10, '0, 1'b0, 1, 1'b1);
        issue("lt_s", 32'hFFFF_FFFF, 32'h1, ALU_LT, MD_ALU, 1'b1, 32'h1, '0, 1'b0, 1, 1'b1);
        issue("lt_u", 32'hFFFF_FFFF, 32'h1, ALU_LT, MD_ALU, 1'b0, 32'h0, '0, 1'b0, 1, 1'b1);
        issue("sub", 32'h5, 32'h7, ALU_SUB, MD_ALU, 1'b0, 32'hFFFF_FFFE, '0, 1'b0, 1, 1'b1);
        issue("and", 32'hF0F0_F0F0, 32'hFF00_FF00, ALU_AND, MD_ALU, 1'b0, 32'hF000_F000, '0, 1'b0, 1, 1'b1);
        issue("or", 32'h0F0F_0000, 32'h0000_F0F0, ALU_OR, MD_ALU, 1'b0, 32'h0F0F_F0F0, '0, 1'b0, 1, 1'b1);
        issue("xor", 32'hAAAA_5555, 32'hFFFF_0000, ALU_XOR, MD_ALU, 1'b0, 32'h5555_5555, '0, 1'b0, 1, 1'b1);
        issue("nor", 32'h0, 32'h0, ALU_NOR, MD_ALU, 1'b0, 32'hFFFF_FFFF, '0, 1'b0, 1, 1'b1);
        issue("pass_a", 32'h1234_5678, 32'h9, ALU_A, MD_ALU, 1'b0, 32'h1234_5678, '0, 1'b0, 1, 1'b1);
        issue("srl", 32'h4, 32'h8000_0000, ALU_SRL, MD_ALU, 1'b0, 32'h0800_0000, '0, 1'b0, 1, 1'b1);
        issue("sra", 32'h24, 32'h8000_0000, ALU_SRA, MD_ALU, 1'b0, 32'hF800_0000, '0, 1'b0, 1, 1'b1);
        issue("eq", 32'h5, 32'h5, ALU_EQ, MD_ALU, 1'b0, 32'h1, '0, 1'b0, 1, 1'b1);
        issue("ne", 32'h5, 32'h5, ALU_NE, MD_ALU, 1'b0, 32'h0, '0, 1'b0, 1, 1'b1);
        issue("lez", 32'h0, 32'h0, ALU_LEZ, MD_ALU, 1'b0, 32'h1, '0, 1'b0, 1, 1'b1);
        issue("ltz", 32'h8000_0000, 32'h0, ALU_LTZ, MD_ALU, 1'b0, 32'h1, '0, 1'b0, 1, 1'b1);
        issue("gtz_neg", 32'hFFFF_FFFF, 32'h0, ALU_GTZ, MD_ALU, 1'b0, 32'h0, '0, 1'b0, 1, 1'b1);
        issue("gtz_pos", 32'h1, 32'h0, ALU_GTZ, MD_ALU, 1'b0, 32'h1, '0, 1'b0, 1, 1'b1);
        issue("undef", 32'h5, 32'h3, 6'b000010, MD_ALU, 1'b0, 32'h0, '0, 1'b0, 1, 1'b1);
        issue("md_rsvd", 32'h2, 32'h3, ALU_ADD, 2'b11, 1'b0, 32'h5, '0, 1'b0, 1, 1'b1);
        wait_empty();

        // Multiply
        issue("mul_s", 32'hFFFF_FFFE, 32'h3, ALU_ADD, MD_MUL, 1'b1, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);
        wait_empty();
        issue("mul_u", 32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_ADD, MD_MUL, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33, 1'b0);
        wait_empty();

        // Divide
`ifdef ALU_MDU_DIV_EN
        issue("div_s", 32'hFFFF_FFF9, 32'h2, ALU_ADD, MD_DIV, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);
        wait_empty();
        issue("div_u", 32'd100, 32'd7, ALU_ADD, MD_DIV, 1'b0, 32'd14, 32'd2, 1'b0, 33, 1'b0);
        wait_empty();
        issue("div_min", 32'h8000_0000, 32'hFFFF_FFFF, ALU_ADD, MD_DIV, 1'b1, 32'h8000_0000, 32'h0, 1'b0, 33, 1'b0);
        wait_empty();
        issue("div_zero", 32'h5, 32'h0, ALU_ADD, MD_DIV, 1'b0, 32'hFFFF_FFFF, 32'h5, 1'b1, 1, 1'b0);
        wait_empty();
`else
        issue("div_off", 32'h8, 32'h2, ALU_ADD, MD_DIV, 1'b0, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        wait_empty();
        issue("div_off_zero", 32'h5, 32'h0, ALU_ADD, MD_DIV, 1'b0, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        wait_empty();
`endif

        // Backpressure on a finished multiply with a new op waiting
        bus.out_ready = 1'b0;
        issue("mul_bp", 32'h7, 32'h6, ALU_ADD, MD_MUL, 1'b0, 32'd42, 32'h0, 1'b0, 33, 1'b0);
        #1;
        t = 0;
        while (!bus.out_valid && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'h2;
        bus.in_b      = 32'h3;
        bus.in_alufun = ALU_ADD;
        bus.in_md     = MD_ALU;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_lo", 64'(bus.out_lo), 64'd42);
            chk("bp_hi", 64'(bus.out_hi), 64'd0);
            @(negedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        issue("add_after_bp", 32'h2, 32'h3, ALU_ADD, MD_ALU, 1'b0, 32'h5, 32'h0, 1'b0, 1, 1'b1);
        wait_empty();

        // Reset while an iterative op is in flight
`ifdef ALU_MDU_DIV_EN
        issue("div_rst", 32'd100, 32'd7, ALU_ADD, MD_DIV, 1'b0, 32'd14, 32'd2, 1'b0, 33, 1'b0);
`else
        issue("mul_rst", 32'd100, 32'd7, ALU_ADD, MD_MUL, 1'b0, 32'd700, 32'd0, 1'b0, 33, 1'b0);
`endif
        repeat (9) @(negedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        #1;
        chk("rst_valid_now", 64'(bus.out_valid), 64'd0);
        chk("rst_lo_now", 64'(bus.out_lo), 64'd0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        n_valid = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) n_valid++;
        end
        chk("rst_no_output", 64'(n_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        issue("add_after_rst", 32'h10, 32'h20, ALU_ADD, MD_ALU, 1'b0, 32'h30, 32'h0, 1'b0, 1, 1'b1);
        wait_empty();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, handshaked successor to the single-cycle datapath ALU. It adds an iterative multiply/divide unit (MIPS HI/LO style) and registers every result behind a valid/ready interface. It sits in the EX stage and lets the pipeline stall on long operations instead of forcing a combinational path.

## Interface
Parameters:
- WIDTH, 32: operand/result width; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridable).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- in_a, in_b  in  WIDTH  operands.
- in_alufun  in  6  function code, used when in_md == 00.
- in_md  in  2  00 ALU, 01 MUL, 10 DIV, 11 reserved (treated as ALU).
- in_sign  in  1  1 = signed, 0 = unsigned.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_lo  out  WIDTH  ALU result, product low half, or quotient.
- out_hi  out  WIDTH  product high half or remainder; 0 for ALU ops.
- out_err  out  1  divide by zero, or DIV when compiled out.

## Operation
- ALU codes by in_alufun[5:4]:
  - 00 add/sub: ADD 000000, SUB 000001.
  - 01 logic: AND 011000, OR 011110, XOR 010110, NOR 010001, PASS-A 011010.
  - 10 shift (B shifted by in_a[SHW-1:0]): SLL 100000, SRL 100001, SRA 100011.
  - 11 compare (result 0/1): EQ 110011, NE 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
  - Undefined codes give 0.
- Arithmetic wraps modulo 2^WIDTH. LT uses in_sign. LEZ/LTZ/GTZ test in_a as signed.
- MUL: radix-2 shift-add over WIDTH iterations on magnitudes; the 2·WIDTH product is negated if signed and the operand signs differ. {out_hi,out_lo} = product.
- DIV: restoring division, WIDTH iterations on magnitudes.
  - Quotient is negative iff the signs differ; the remainder takes the dividend's sign.
  - MIN / -1 yields quotient MIN, remainder 0.
  - in_b == 0: no iteration; out_lo = all ones, out_hi = in_a, out_err = 1.
- FSM states:
  - IDLE: accepting. ALU op or div-by-zero → DONE; MUL/DIV → BUSY with count = WIDTH-1.
  - BUSY: one iteration per cycle; at count 0 → DONE.
  - DONE: out_valid = 1. If out_ready: → IDLE, or directly take the next op when in_valid (same transitions as IDLE).
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- Outputs stay stable while out_valid && !out_ready.

## Timing
- Reset: state IDLE; out_valid, out_err, out_lo, out_hi = 0; in_ready = 1 the cycle after reset deasserts.
- Latency from acceptance edge to out_valid: ALU op and div-by-zero 1 cycle; MUL/DIV WIDTH+1 cycles.
- Back-to-back ALU ops with out_ready held high: one result per cycle.
- Operands are captured at acceptance; later changes on in_a, in_b, etc. have no effect.
- Reset mid-BUSY: operation dropped, nothing is emitted.
- out_ready is ignored while out_valid = 0.

## Configuration
- ALU_MDU_DIV_EN defined: divider built as above.
- Not defined: no divider logic. DIV ops complete in 1 cycle with out_lo = out_hi = 0 and out_err = 1. MUL is unaffected.

## Structure
- Package alu_pkg holds:
  - the function-code localparams (ALU_ADD … ALU_GTZ);
  - MD_ALU, MD_MUL, MD_DIV;
  - the FSM state encoding (IDLE, BUSY, DONE).
- Sub-module alu_core: combinational single-cycle ALU (WIDTH-parametrised), instantiated once.
- The multiply/divide iteration and the FSM live in alu_mdu.

## Test plan
- ALU: ADD 7FFFFFFF+1 → 80000000; SLL with A=4, B=1 → 10; LT signed -1<1 → 1, unsigned → 0. Each with 1-cycle latency, back-to-back at one result per cycle.
- MUL signed FFFFFFFE×00000003 → hi FFFFFFFF, lo FFFFFFFA; out_valid exactly 33 cycles after acceptance.
- DIV signed -7/2 → lo FFFFFFFD, hi FFFFFFFF. DIV 5/0 → lo FFFFFFFF, hi 5, err 1, 1 cycle.
- Backpressure: out_ready low for 5 cycles after a MUL completes → outputs and out_valid held, in_ready 0. Release → next op accepted the same cycle.
- Reset asserted at iteration 10 of DIV → out_valid 0 immediately and stays 0; a new ADD after reset returns the correct result.
- Build without ALU_MDU_DIV_EN → DIV 8/2 gives err 1 and zero results in 1 cycle; MUL still correct.
